// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the fan push-button front end: channel indices,
// default auto-repeat mask and the millisecond-to-cycle conversion.
package btn_conditioner_pkg;

    localparam int unsigned N_BTN_DEFAULT = 7;

    localparam int unsigned BTN_POWER    = 0;
    localparam int unsigned BTN_SPEED_UP = 1;
    localparam int unsigned BTN_SPEED_DN = 2;
    localparam int unsigned BTN_TIMER    = 3;
    localparam int unsigned BTN_LIGHT    = 4;
    localparam int unsigned BTN_ROTATE   = 5;
    localparam int unsigned BTN_MODE     = 6;

    // Speed up/down auto-repeat; every other button fires once per press.
    localparam logic [6:0] DEFAULT_REPEAT_EN = 7'b000_0110;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce, hold timer and optional
// auto-repeat. All outputs are registered.
module btn_channel #(
    parameter int unsigned DEB_CYC  = 1,
    parameter int unsigned LONG_CYC = 2,
    parameter int unsigned REP_CYC  = 1,
    parameter bit          REPEAT   = 1'b0
) (
    input  logic clk,
    input  logic reset_p,
    input  logic raw,
    output logic level,
    output logic pedge,
    output logic nedge,
    output logic long_press
);
    localparam int unsigned DW = $clog2(DEB_CYC + 1);
    localparam int unsigned HW = $clog2(LONG_CYC + 1);
    localparam int unsigned RW = $clog2(REP_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYC - 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;

    logic sync;
    logic flip;
    logic stable_nxt;
    logic held;
    logic at_long;
    logic rep_hit;

    assign sync = sync_q[1];

    // Look one cycle ahead at the debounced level so that pulses line up with
    // the cycle in which level first shows the new value, and a release never
    // coincides with a repeat pulse.
    always_comb begin
        flip       = (sync != level) && (dcnt == DEB_LAST);
        stable_nxt = flip ? sync : level;
        held       = level && stable_nxt;
        at_long    = held && (hcnt == HOLD_LAST);
        rep_hit    = REPEAT && at_long && (rcnt == REP_LAST);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync_q     <= '0;
            dcnt       <= '0;
            hcnt       <= '0;
            rcnt       <= '0;
            level      <= 1'b0;
            pedge      <= 1'b0;
            nedge      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw};
            dcnt       <= ((sync == level) || flip) ? '0 : dcnt + DW'(1);
            level      <= stable_nxt;
            pedge      <= (flip && sync) || rep_hit;
            nedge      <= flip && !sync;
            long_press <= held && (hcnt == HOLD_PRE);
            // Hold timer saturates at the long-press point; repeat phase runs from there.
            hcnt       <= !held ? '0 : ((hcnt == HOLD_LAST) ? hcnt : hcnt + HW'(1));
            rcnt       <= at_long ? ((rcnt == REP_LAST) ? '0 : rcnt + RW'(1)) : '0;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: N_BTN independent debounce/edge/long-press channels
// feeding the fan controller and the buzzer stage.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned     N_BTN       = N_BTN_DEFAULT,
    parameter int unsigned     CLK_HZ      = 100_000_000,
    parameter int unsigned     DEBOUNCE_MS = 10,
    parameter int unsigned     LONG_MS     = 1000,
    parameter int unsigned     REPEAT_MS   = 200,
    parameter logic [N_BTN-1:0] REPEAT_EN  = N_BTN'(DEFAULT_REPEAT_EN)
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pedge,
    output logic [N_BTN-1:0] btn_nedge,
    output logic [N_BTN-1:0] btn_long
);
    localparam int unsigned DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int unsigned REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

    if ((DEB_CYC < 1) || (LONG_CYC < 1) || (REP_CYC < 1)) begin : g_bad_cyc
        $error("btn_conditioner: derived cycle counts must be at least 1");
    end
    if (LONG_CYC <= DEB_CYC) begin : g_bad_long
        $error("btn_conditioner: LONG_CYC must exceed DEB_CYC");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC),
            .REPEAT   (REPEAT_EN[i])
        ) u_ch (
            .clk        (clk),
            .reset_p    (reset_p),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .pedge      (btn_pedge[i]),
            .nedge      (btn_nedge[i]),
            .long_press (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed vectors and sequences plus random
// button activity checked every cycle against a sliding-window model.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int N    = 7;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam logic [N-1:0] REP_EN = 7'b0000010;

    logic         clk;
    logic         reset_p;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_pedge, btn_nedge, btn_long;

    btn_conditioner #(
        .N_BTN       (N),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .REPEAT_MS   (REP),
        .REPEAT_EN   (REP_EN)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pedge (btn_pedge),
        .btn_nedge (btn_nedge),
        .btn_long  (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: level flips once the last DEB synchronised samples all
    // disagree with it; pulses follow from the level history and run length.
    logic [N-1:0] win_q[$];
    int unsigned  m_run[N];
    logic [N-1:0] m_level, e_pe, e_ne, e_lg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle time %0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        win_q.delete();
        for (int i = 0; i < DEB + 1; i++) win_q.push_back('0);
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_level = '0; e_pe = '0; e_ne = '0; e_lg = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] prev, s;
        bit all_diff;
        win_q.push_back(btn_raw);
        prev = m_level;
        for (int ch = 0; ch < N; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = win_q[j];
                if (s[ch] == m_level[ch]) all_diff = 1'b0;
            end
            if (all_diff) m_level[ch] = ~m_level[ch];
            m_run[ch] = m_level[ch] ? m_run[ch] + 1 : 0;
            e_pe[ch] = (m_level[ch] && !prev[ch]) ||
                       (REP_EN[ch] && m_level[ch] && m_run[ch] > LONG && ((m_run[ch] - LONG) % REP) == 0);
            e_ne[ch] = !m_level[ch] && prev[ch];
            e_lg[ch] = m_level[ch] && (m_run[ch] == LONG);
        end
        void'(win_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_p) model_reset();
        else model_step();
        @(negedge clk);
        check("model", 32'({btn_level, btn_pedge, btn_nedge, btn_long}),
                       32'({m_level, e_pe, e_ne, e_lg}));
    endtask

    typedef struct packed {
        logic raw;
        logic lvl;
        logic pe;
        logic ne;
    } vec_t;
    vec_t tbl[14];

    int lc, pcnt, ncnt, lcnt, lg_at, post, at, ne0, ne4;
    bit seen_ne;
    int pe_at[$];
    int exp_pe[5];
    int unsigned dur[N];

    initial begin
        // Clean press/release on the power button: raw, level, pedge, nedge per cycle.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_pe = '{1, 25, 30, 35, 40};

        btn_raw = '0;
        reset_p = 1'b1;
        model_reset();
        repeat (3) tick();
        check("reset_state", 32'({btn_level, btn_pedge, btn_nedge, btn_long}), 32'd0);
        reset_p = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 14; i++) begin
            btn_raw[BTN_POWER] = tbl[i].raw;
            tick();
            check($sformatf("clean_row%0d", i),
                  32'({btn_level[BTN_POWER], btn_pedge[BTN_POWER], btn_nedge[BTN_POWER]}),
                  32'({tbl[i].lvl, tbl[i].pe, tbl[i].ne}));
        end
        repeat (5) tick();

        // Bounce: three 1-cycle transitions, final rise sampled on the first loop edge.
        btn_raw[BTN_SPEED_DN] = 1'b1; tick();
        btn_raw[BTN_SPEED_DN] = 1'b0; tick();
        btn_raw[BTN_SPEED_DN] = 1'b1;
        pcnt = 0; at = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (btn_pedge[BTN_SPEED_DN]) begin pcnt++; at = t; end
        end
        check("bounce_pedge_count", 32'(pcnt), 32'd1);
        check("bounce_pedge_cycle", 32'(at), 32'd6);
        btn_raw[BTN_SPEED_DN] = 1'b0;
        repeat (10) tick();

        // 3-cycle glitch never reaches the debounced level.
        btn_raw[BTN_ROTATE] = 1'b1;
        repeat (3) tick();
        btn_raw[BTN_ROTATE] = 1'b0;
        pcnt = 0; lc = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (btn_pedge[BTN_ROTATE]) pcnt++;
            if (btn_level[BTN_ROTATE]) lc++;
        end
        check("glitch_pedge_count", 32'(pcnt), 32'd0);
        check("glitch_level_cycles", 32'(lc), 32'd0);

        // Long press on a non-repeating button.
        btn_raw[BTN_POWER] = 1'b1;
        lc = 0; pcnt = 0; lcnt = 0; lg_at = 0; ncnt = 0;
        for (int t = 0; t < 46; t++) begin
            tick();
            if (btn_level[BTN_POWER]) lc++;
            if (btn_pedge[BTN_POWER]) pcnt++;
            if (btn_long[BTN_POWER]) begin lcnt++; lg_at = lc; end
        end
        btn_raw[BTN_POWER] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (btn_nedge[BTN_POWER]) ncnt++;
            if (btn_pedge[BTN_POWER]) pcnt++;
        end
        check("long_cycle", 32'(lg_at), 32'(LONG));
        check("long_count", 32'(lcnt), 32'd1);
        check("long_pedge_count", 32'(pcnt), 32'd1);
        check("long_nedge_count", 32'(ncnt), 32'd1);

        // Auto-repeat on speed-up, released during level-cycle 37.
        btn_raw[BTN_SPEED_UP] = 1'b1;
        lc = 0; ncnt = 0; post = 0; lg_at = 0; seen_ne = 1'b0;
        pe_at.delete();
        for (int t = 0; t < 60; t++) begin
            tick();
            if (btn_level[BTN_SPEED_UP]) lc++;
            if (btn_nedge[BTN_SPEED_UP]) begin ncnt++; seen_ne = 1'b1; end
            if (btn_pedge[BTN_SPEED_UP]) begin
                if (seen_ne) post++;
                else pe_at.push_back(lc);
            end
            if (btn_long[BTN_SPEED_UP]) lg_at = lc;
            if (lc == 37 && btn_level[BTN_SPEED_UP]) btn_raw[BTN_SPEED_UP] = 1'b0;
        end
        check("rep_long_cycle", 32'(lg_at), 32'(LONG));
        check("rep_pedge_count", 32'(pe_at.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rep_pedge%0d_cycle", i),
                  32'((i < pe_at.size()) ? pe_at[i] : 0), 32'(exp_pe[i]));
        check("rep_post_release_pedge", 32'(post), 32'd0);
        check("rep_nedge_count", 32'(ncnt), 32'd1);
        repeat (5) tick();

        // Simultaneous press, staggered release.
        btn_raw[BTN_POWER] = 1'b1;
        btn_raw[BTN_LIGHT] = 1'b1;
        repeat (6) tick();
        check("simul_pedge", 32'(btn_pedge), 32'(7'b0010001));
        repeat (5) tick();
        btn_raw[BTN_LIGHT] = 1'b0;
        ne0 = 0; ne4 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 4) btn_raw[BTN_POWER] = 1'b0;
            tick();
            if (btn_nedge[BTN_LIGHT]) ne4 = t;
            if (btn_nedge[BTN_POWER]) ne0 = t;
        end
        check("simul_nedge_light", 32'(ne4), 32'd6);
        check("simul_nedge_power", 32'(ne0), 32'd9);

        // Reset while the timer button is held.
        btn_raw[BTN_TIMER] = 1'b1;
        repeat (8) tick();
        check("rst_pre_level", 32'(btn_level[BTN_TIMER]), 32'd1);
        reset_p = 1'b1;
        #1;
        check("rst_async_zero", 32'({btn_level, btn_pedge, btn_nedge, btn_long}), 32'd0);
        tick();
        tick();
        reset_p = 1'b0;
        at = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (btn_pedge[BTN_TIMER] && at == 0) at = t;
        end
        check("rst_fresh_pedge", 32'(at), 32'd6);
        btn_raw[BTN_TIMER] = 1'b0;
        repeat (10) tick();

        // Random activity: mostly short bursts, some long holds, rare resets.
        for (int i = 0; i < N; i++) dur[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    btn_raw[ch] = ~btn_raw[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 7);
                end else begin
                    dur[ch]--;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                reset_p = 1'b1;
                #1;
                check("rand_rst_zero", 32'({btn_level, btn_pedge, btn_nedge, btn_long}), 32'd0);
                tick();
                reset_p = 1'b0;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
